// File: rtl/ascon_feeder_pkg.sv
// ascon_feeder_pkg
//   Shared types and constants for the ASCON block feeder.
//   state_t   : feeder FSM states, IDLE .. DONE
//   BEATS     : host beats per 64-bit block
//   BLK_IDX_W : width of the block index (A1, P1, P2, P3)
package ascon_feeder_pkg;

  localparam int FEED_IN_W     = 8;
  localparam int FEED_BLOCK_W  = 64;
  localparam int FEED_N_BLOCKS = 4;
  localparam int BEATS         = FEED_BLOCK_W / FEED_IN_W;
  localparam int BLK_IDX_W     = 2;

  typedef enum logic [2:0] {
    IDLE,
    START,
    FILL,
    HOLD,
    PRESENT,
    ACK,
    DONE
  } state_t;

endpackage

// File: rtl/ascon_byte_packer.sv
// ascon_byte_packer
//   Packs host beats MSB-first into one block and counts beats.
//   clock_i   : clock, rising edge
//   reset_i   : synchronous active-high reset
//   clear     : drop any partial block and restart the beat count
//   shift_en  : a beat is accepted this cycle
//   data      : the beat being accepted
//   word      : the block as it stands including the current beat, so the
//               caller can capture it on the same edge as the last beat
//   complete  : the current beat is the last beat of a block
module ascon_byte_packer #(
  parameter int IN_W    = 8,
  parameter int BLOCK_W = 64
) (
  input  logic               clock_i,
  input  logic               reset_i,
  input  logic               clear,
  input  logic               shift_en,
  input  logic [IN_W-1:0]    data,
  output logic [BLOCK_W-1:0] word,
  output logic               complete
);

  localparam int NUM_BEATS = BLOCK_W / IN_W;
  localparam int CNT_W     = $clog2(NUM_BEATS);
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(NUM_BEATS - 1);

  logic [BLOCK_W-1:0] shift_reg;
  logic [CNT_W-1:0]   count_reg;

  assign word     = {shift_reg[BLOCK_W-IN_W-1:0], data};
  assign complete = shift_en && (count_reg == LAST_BEAT);

  always_ff @(posedge clock_i) begin
    if (reset_i || clear) begin
      shift_reg <= '0;
      count_reg <= '0;
    end else if (shift_en) begin
      shift_reg <= word;
      // wrap on the last beat so the next block starts from zero
      count_reg <= complete ? '0 : count_reg + 1'b1;
    end
  end

endmodule

// File: rtl/ascon_block_feeder.sv
// ascon_block_feeder
//   Upstream stage of the ASCON control FSM. Packs the host byte stream into
//   four 64-bit blocks (A1, P1, P2, P3), pulses start_o once per message and
//   presents each block with a one-cycle data_valid_o while the FSM waits.
//   clock_i      : clock, rising edge
//   reset_i      : synchronous active-high reset
//   start_req_i  : begin a message (only looked at in IDLE)
//   s_data_i     : host beat, MSB-first within a block
//   s_valid_i    : host beat valid
//   s_ready_o    : feeder accepts a beat this cycle
//   fsm_wait_i   : FSM parked in one of its end_* wait phases
//   fsm_end_i    : FSM end pulse
//   start_o      : one-cycle start pulse to the FSM
//   data_valid_o : one-cycle block-valid pulse to the FSM
//   block_o      : block for the FSM datapath, changes only when a block fills
//   block_idx_o  : index of the block in block_o
//   busy_o       : message in progress
//   done_o       : one-cycle message-complete pulse
module ascon_block_feeder
  import ascon_feeder_pkg::*;
#(
  parameter int IN_W     = FEED_IN_W,
  parameter int BLOCK_W  = FEED_BLOCK_W,
  parameter int N_BLOCKS = FEED_N_BLOCKS
) (
  input  logic                 clock_i,
  input  logic                 reset_i,
  input  logic                 start_req_i,
  input  logic [IN_W-1:0]      s_data_i,
  input  logic                 s_valid_i,
  output logic                 s_ready_o,
  input  logic                 fsm_wait_i,
  input  logic                 fsm_end_i,
  output logic                 start_o,
  output logic                 data_valid_o,
  output logic [BLOCK_W-1:0]   block_o,
  output logic [BLK_IDX_W-1:0] block_idx_o,
  output logic                 busy_o,
  output logic                 done_o
);

  localparam logic [BLK_IDX_W-1:0] LAST_IDX = BLK_IDX_W'(N_BLOCKS - 1);

  state_t                 state_reg;
  logic                   start_reg;
  logic                   data_valid_reg;
  logic                   s_ready_reg;
  logic                   busy_reg;
  logic                   done_reg;
  logic [BLOCK_W-1:0]     block_reg;
  logic [BLK_IDX_W-1:0]   block_idx_reg;
  logic [BLK_IDX_W-1:0]   cur_idx_reg;

  logic                   beat_fire;
  logic                   packer_clear;
  logic                   block_complete;
  logic [BLOCK_W-1:0]     packed_word;

  // s_ready_reg is only ever high in FILL, so this is the FILL handshake
  assign beat_fire    = s_valid_i & s_ready_reg;
  // fresh block count at message start and when moving on to the next block
  assign packer_clear = (state_reg == START) || ((state_reg == ACK) && !fsm_wait_i);

  ascon_byte_packer #(
    .IN_W    (IN_W),
    .BLOCK_W (BLOCK_W)
  ) u_packer (
    .clock_i  (clock_i),
    .reset_i  (reset_i),
    .clear    (packer_clear),
    .shift_en (beat_fire),
    .data     (s_data_i),
    .word     (packed_word),
    .complete (block_complete)
  );

  // Outputs are registered alongside the state so that each one is set on
  // the edge entering the state it belongs to.
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_reg      <= IDLE;
      start_reg      <= 1'b0;
      data_valid_reg <= 1'b0;
      s_ready_reg    <= 1'b0;
      busy_reg       <= 1'b0;
      done_reg       <= 1'b0;
      block_reg      <= '0;
      block_idx_reg  <= '0;
      cur_idx_reg    <= '0;
    end else begin
      start_reg      <= 1'b0;
      data_valid_reg <= 1'b0;
      done_reg       <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (start_req_i) begin
            state_reg <= START;
            start_reg <= 1'b1;
            busy_reg  <= 1'b1;
          end
        end
        START: begin
          cur_idx_reg <= '0;
          s_ready_reg <= 1'b1;
          state_reg   <= FILL;
        end
        FILL: begin
          if (beat_fire && block_complete) begin
            block_reg     <= packed_word;
            block_idx_reg <= cur_idx_reg;
            s_ready_reg   <= 1'b0;
            state_reg     <= HOLD;
          end
        end
        HOLD: begin
          // block 0 waits here through the FSM's initialisation rounds
          if (fsm_wait_i) begin
            data_valid_reg <= 1'b1;
            state_reg      <= PRESENT;
          end
        end
        PRESENT: begin
          state_reg <= ACK;
        end
        ACK: begin
          // fsm_wait_i still high means the FSM has not taken the block yet
          if (!fsm_wait_i) begin
            if (cur_idx_reg == LAST_IDX) begin
              state_reg <= DONE;
            end else begin
              cur_idx_reg <= cur_idx_reg + 1'b1;
              s_ready_reg <= 1'b1;
              state_reg   <= FILL;
            end
          end
        end
        DONE: begin
          if (fsm_end_i) begin
            done_reg  <= 1'b1;
            busy_reg  <= 1'b0;
            state_reg <= IDLE;
          end
        end
        default: begin
          state_reg   <= IDLE;
          s_ready_reg <= 1'b0;
          busy_reg    <= 1'b0;
        end
      endcase
    end
  end

  assign start_o      = start_reg;
  assign data_valid_o = data_valid_reg;
  assign s_ready_o    = s_ready_reg;
  assign busy_o       = busy_reg;
  assign done_o       = done_reg;
  assign block_o      = block_reg;
  assign block_idx_o  = block_idx_reg;

endmodule

// File: tb/tb_ascon_block_feeder.sv
module tb_ascon_block_feeder;
  import ascon_feeder_pkg::*;

  logic        clock_i = 1'b0;
  logic        reset_i = 1'b1;
  logic        start_req_i = 1'b0;
  logic [7:0]  s_data_i = 8'h00;
  logic        s_valid_i = 1'b0;
  logic        s_ready_o;
  logic        fsm_wait_i = 1'b0;
  logic        fsm_end_i = 1'b0;
  logic        start_o;
  logic        data_valid_o;
  logic [63:0] block_o;
  logic [1:0]  block_idx_o;
  logic        busy_o;
  logic        done_o;

  ascon_block_feeder dut (
    .clock_i      (clock_i),
    .reset_i      (reset_i),
    .start_req_i  (start_req_i),
    .s_data_i     (s_data_i),
    .s_valid_i    (s_valid_i),
    .s_ready_o    (s_ready_o),
    .fsm_wait_i   (fsm_wait_i),
    .fsm_end_i    (fsm_end_i),
    .start_o      (start_o),
    .data_valid_o (data_valid_o),
    .block_o      (block_o),
    .block_idx_o  (block_idx_o),
    .busy_o       (busy_o),
    .done_o       (done_o)
  );

  always #5 clock_i = ~clock_i;

  int checks = 0;
  int errors = 0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  typedef struct {
    logic [63:0] blk;
    logic [1:0]  idx;
  } exp_t;
  exp_t sb_q[$];

  // FSM model / monitor state
  int          wait_cnt = -1;
  int          end_cnt = -1;
  int          lat = 0;
  bit          lat_on = 0;
  bit          bp_mode = 0;
  bit          bp_active = 0;
  bit          spur_end_req = 0;
  int          start_cnt = 0;
  int          dv_cnt = 0;
  int          done_cnt = 0;
  logic [63:0] bp_block = '0;

  // Control-FSM model and output monitor, evaluated on the falling edge.
  always @(negedge clock_i) begin
    exp_t e;
    fsm_end_i = 1'b0;
    if (reset_i) begin
      wait_cnt = -1;
      end_cnt = -1;
      fsm_wait_i = 1'b0;
      lat_on = 0;
      bp_active = 0;
      spur_end_req = 0;
    end else begin
      if (spur_end_req) begin
        fsm_end_i = 1'b1;
        spur_end_req = 0;
      end
      if (lat_on) lat++;
      if (start_o) begin
        start_cnt++;
        wait_cnt = 14;
      end
      if (done_o) done_cnt++;
      if (data_valid_o) begin
        dv_cnt++;
        check_val("sb_nonempty", 64'(sb_q.size() != 0), 64'd1);
        if (sb_q.size() != 0) begin
          e = sb_q.pop_front();
          $display("block idx=%0d got=%h exp=%h", block_idx_o, block_o, e.blk);
          check_val("block", block_o, e.blk);
          check_val("block_idx", 64'(block_idx_o), 64'(e.idx));
        end
        if (bp_active) begin
          check_val("bp_dv_latency", 64'(lat <= 2), 64'd1);
          bp_active = 0;
        end
        lat_on = 0;
        fsm_wait_i = 1'b0;
        if (block_idx_o == 2'd3) end_cnt = 5;
        else if (bp_mode && block_idx_o == 2'd0) begin
          wait_cnt = 50;
          bp_active = 1;
        end else wait_cnt = 4;
      end
      // block 1 is packed and parked in HOLD for this part of the long wait
      if (bp_active && wait_cnt >= 2 && wait_cnt <= 30) begin
        check_val("bp_ready_low", 64'(s_ready_o), 64'd0);
        check_val("bp_block_stable", block_o, bp_block);
      end
      if (wait_cnt > 0) begin
        wait_cnt--;
        if (wait_cnt == 0) begin
          fsm_wait_i = 1'b1;
          wait_cnt = -1;
          lat = 0;
          lat_on = 1;
        end
      end
      if (end_cnt > 0) begin
        end_cnt--;
        if (end_cnt == 0) begin
          fsm_end_i = 1'b1;
          end_cnt = -1;
        end
      end
    end
  end

  task automatic send_beat(input logic [7:0] d);
    int n;
    n = 0;
    s_data_i = d;
    s_valid_i = 1'b1;
    forever begin
      @(negedge clock_i);
      if (s_ready_o) begin
        @(posedge clock_i);
        #1;
        break;
      end
      n++;
      if (n > 300) begin
        check_val("beat_timeout", 64'(s_ready_o), 64'd1);
        break;
      end
    end
  endtask

  task automatic send_block(input logic [7:0] base, input logic [1:0] idx,
                            input bit bursty, input bit spur_start);
    logic [63:0] w;
    w = '0;
    for (int b = 0; b < 8; b++) begin
      send_beat(8'(base + 8'(b)));
      w = {w[55:0], 8'(base + 8'(b))};
      if (b == 0 && idx == 2'd0) check_val("busy_mid", 64'(busy_o), 64'd1);
      start_req_i = (spur_start && b == 3);
      if (b == 7) sb_q.push_back('{w, idx});
      if (bursty) begin
        s_valid_i = 1'b0;
        repeat (2) @(posedge clock_i);
        #1;
      end
    end
  endtask

  task automatic pulse_start();
    @(posedge clock_i);
    #1 start_req_i = 1'b1;
    @(posedge clock_i);
    #1 start_req_i = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check_val({tag, "_ctl"}, 64'({start_o, data_valid_o, s_ready_o, busy_o, done_o, block_idx_o}), 64'd0);
    check_val({tag, "_block"}, block_o, 64'd0);
  endtask

  task automatic run_message(input logic [7:0] base, input bit bursty, input bit bp, input bit spur);
    int s0, d0, n0, n;
    s0 = start_cnt;
    d0 = dv_cnt;
    n0 = done_cnt;
    bp_mode = bp;
    bp_block = '0;
    for (int b = 8; b < 16; b++) bp_block = {bp_block[55:0], 8'(base + 8'(b))};
    pulse_start();
    for (int blk = 0; blk < 4; blk++) begin
      send_block(8'(base + 8'(8 * blk)), 2'(blk), bursty, spur && blk == 1);
      if (spur && blk == 0) spur_end_req = 1;
    end
    s_valid_i = 1'b0;
    n = 0;
    while (n < 600) begin
      @(negedge clock_i);
      if (done_o) break;
      n++;
    end
    check_val("done_seen", 64'(done_o), 64'd1);
    check_val("busy_after_done", 64'(busy_o), 64'd0);
    @(posedge clock_i);
    #1;
    check_val("start_count", 64'(start_cnt - s0), 64'd1);
    check_val("dv_count", 64'(dv_cnt - d0), 64'd4);
    check_val("done_count", 64'(done_cnt - n0), 64'd1);
    check_val("sb_drained", 64'(sb_q.size()), 64'd0);
    $display("message base=%h bursty=%0d bp=%0d spur=%0d complete", base, bursty, bp, spur);
    bp_mode = 0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // reset held with a valid beat on the bus
    reset_i = 1'b1;
    s_valid_i = 1'b1;
    s_data_i = 8'hA5;
    @(posedge clock_i);
    repeat (3) begin
      @(negedge clock_i);
      check_all_zero("reset");
    end
    @(posedge clock_i);
    #1 reset_i = 1'b0;
    s_valid_i = 1'b0;
    @(negedge clock_i);
    check_all_zero("post_reset");

    run_message(8'h00, 1'b0, 1'b0, 1'b0);  // nominal
    run_message(8'h20, 1'b0, 1'b1, 1'b0);  // backpressure on block 1
    run_message(8'h00, 1'b1, 1'b0, 1'b0);  // bursty host
    run_message(8'h40, 1'b0, 1'b0, 1'b1);  // spurious start/end

    // reset after 5 beats of block 2
    pulse_start();
    send_block(8'h80, 2'd0, 1'b0, 1'b0);
    send_block(8'h88, 2'd1, 1'b0, 1'b0);
    for (int b = 0; b < 5; b++) send_beat(8'(8'h90 + 8'(b)));
    s_valid_i = 1'b0;
    reset_i = 1'b1;
    @(posedge clock_i);
    @(negedge clock_i);
    check_all_zero("mid_reset");
    check_val("mid_reset_sb", 64'(sb_q.size()), 64'd0);
    @(posedge clock_i);
    #1 reset_i = 1'b0;
    $display("mid-message reset applied");

    run_message(8'hA0, 1'b0, 1'b0, 1'b0);  // fresh message after reset

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ascon_block_feeder.md
Name: ascon_block_feeder

Overview:
- Upstream stage of the ASCON encryption control FSM.
- Accepts the host byte stream on a valid/ready handshake and packs it into 64-bit blocks in the order A1, P1, P2, P3.
- Issues the one-cycle start pulse to the control FSM.
- Presents each block with a one-cycle data_valid pulse, only while the FSM reports that it is parked in an idle/wait phase.

Parameters:
- IN_W, 8, width of one host beat in bits.
- BLOCK_W, 64, width of one ASCON data block; BEATS = BLOCK_W/IN_W = 8.
- N_BLOCKS, 4, blocks per message (associated data A1, then plaintext P1, P2, P3).

Ports:
- clock_i  in  1  single clock, rising edge.
- reset_i  in  1  reset, synchronous, active-high.
- start_req_i  in  1  host request to begin a message; sampled only in IDLE.
- s_data_i  in  IN_W  host data beat, MSB-first within the block.
- s_valid_i  in  1  host beat valid.
- s_ready_o  out  1  feeder accepts a beat this cycle.
- fsm_wait_i  in  1  OR of the FSM's end_initialisation, end_associate, end_cipher1 and end_cipher2 levels.
- fsm_end_i  in  1  FSM end pulse.
- start_o  out  1  one-cycle start pulse to the FSM.
- data_valid_o  out  1  one-cycle block-valid pulse to the FSM.
- block_o  out  BLOCK_W  current block for the FSM datapath.
- block_idx_o  out  2  index of the block held in block_o (0 = A1 … 3 = P3).
- busy_o  out  1  high from START until DONE exits.
- done_o  out  1  one-cycle pulse when the message completes.

Behaviour:
Reset and conventions
- Reset is synchronous and active-high, applied on clock_i: state goes to IDLE and every register clears (shift register, beat count, block index).
- Every output is 0 during and after reset, including block_o = 0 and block_idx_o = 0.
- All outputs are registered or Moore-decoded from the state; no combinational path from any input to any output.

States and transitions
- IDLE: start_req_i=1 → START; otherwise stay.
- START: start_o=1 for exactly 1 cycle; clear beat count and block index; → FILL.
- FILL:
  - s_ready_o=1.
  - Each cycle with s_valid_i & s_ready_o: shift <= {shift[BLOCK_W-IN_W-1:0], s_data_i}, beat count +1.
  - On the 8th beat, the same edge loads block_o with the completed word, updates block_idx_o and moves to HOLD.
- HOLD:
  - s_ready_o=0.
  - Wait for fsm_wait_i=1, then → PRESENT.
  - For block 0, fsm_wait_i rises only after the 12-round initialisation, so the first block is prefetched while the FSM initialises.
- PRESENT: data_valid_o=1 for exactly 1 cycle; → ACK.
- ACK:
  - Wait for fsm_wait_i=0, i.e. the FSM has left its idle state.
  - If block index = N_BLOCKS-1 → DONE; else block index +1, beat count 0, → FILL.
- DONE:
  - busy_o stays 1.
  - On fsm_end_i=1: done_o=1 for 1 cycle, busy_o=0, → IDLE.

Output stability and timing
- block_o changes only on the FILL→HOLD edge. It stays stable for at least BEATS cycles after data_valid_o, which covers the FSM's conf and end_conf consumption cycles.
- Minimum latency from the 8th accepted beat to data_valid_o: 2 cycles (HOLD with fsm_wait_i already high, then PRESENT).

Boundary conditions
- start_req_i outside IDLE: ignored.
- s_valid_i while s_ready_o=0: beat not consumed; the host holds it.
- s_valid_i gaps in FILL: beat count holds; no timeout.
- fsm_wait_i high during FILL: ignored until HOLD.
- fsm_end_i outside DONE: ignored.
- reset_i mid-message: immediate return to IDLE with all outputs 0; any partial block is discarded.

Decomposition:
- Package ascon_feeder_pkg:
  - state_t enum {IDLE, START, FILL, HOLD, PRESENT, ACK, DONE};
  - constants BEATS and BLK_IDX_W = 2.
- Sub-module ascon_byte_packer: shift register, beat counter and the "block complete" flag, with inputs shift_en/clear and output word.
- The top level holds the FSM, the block_o/block_idx_o registers and the pulse outputs.

Test Plan:
1. Reset: hold reset_i 3 cycles with s_valid_i=1 → all outputs 0, s_ready_o=0, state IDLE.
2. Nominal message:
   - Stimulus: start_req_i pulse; 32 beats 0x00..0x1F with s_valid_i always high; FSM model raises fsm_wait_i 14 cycles after start_o and drops it 1 cycle after each data_valid_o.
   - Required: start_o exactly once; four data_valid_o pulses with block_o = 0x0001020304050607, 0x08090A0B0C0D0E0F, 0x1011121314151617, 0x18191A1B1C1D1E1F and block_idx_o = 0..3; done_o on the fsm_end_i pulse.
3. Backpressure: fsm_wait_i held low for 50 cycles after block 1 is packed → s_ready_o=0 and no beat accepted during the wait; data_valid_o occurs 2 cycles after fsm_wait_i rises; block_o is unchanged for the whole wait.
4. Bursty host: s_valid_i toggling 1,0,0,1 → block value identical to scenario 2; beat count advances only on handshakes.
5. Spurious inputs: start_req_i pulsed during FILL and fsm_end_i pulsed during HOLD → no second start_o, no early done_o.
6. Reset mid-block: reset_i asserted after 5 beats of block 2 → outputs 0 the next cycle; a fresh message afterwards produces block 0 correctly from 8 new beats.
